// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fnd_pkg
// Brief   : Shared types, limits and the double-dabble helper for the FND path.
// Revision: 1.0  initial release
// ============================================================================
package fnd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam int FND_DIGITS = 4;
    localparam int FND_MAX    = 9999;
    localparam int BCD_W      = 4;
    localparam int BCD_VEC_W  = FND_DIGITS * BCD_W;

    // Add 3 to every BCD digit that is 5 or more, ahead of the next left shift.
    function automatic logic [BCD_VEC_W-1:0] dd_adjust(input logic [BCD_VEC_W-1:0] bcd);
        logic [BCD_VEC_W-1:0] r;
        r = bcd;
        for (int k = 0; k < FND_DIGITS; k++) begin
            if (r[k*BCD_W +: BCD_W] >= 4'd5) begin
                r[k*BCD_W +: BCD_W] = r[k*BCD_W +: BCD_W] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module  : bin2bcd_seq
// Brief   : Saturating capture plus one-bit-per-clock double-dabble conversion.
// Revision: 1.0  initial release
// ============================================================================
module bin2bcd_seq
    import fnd_pkg::*;
#(
    parameter int DATA_W = 14
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [DATA_W-1:0]    value_i,
    input  logic                 load_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 ovf_o,
    output logic [BCD_VEC_W-1:0] bcd_o
);

    localparam int STEP_W = $clog2(DATA_W + 1);

    conv_state_e            state_q, state_d;
    logic [DATA_W-1:0]      bin_q, bin_d;
    logic [BCD_VEC_W-1:0]   bcd_q, bcd_d;
    logic [STEP_W-1:0]      cnt_q, cnt_d;
    logic                   ovf_q, ovf_d;
    logic                   w_sat;
    logic [BCD_VEC_W-1:0]   w_adj;

    assign w_sat = (32'(value_i) > 32'(FND_MAX));
    assign w_adj = dd_adjust(bcd_q);

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    bin_d   = w_sat ? DATA_W'(FND_MAX) : value_i;
                    ovf_d   = w_sat;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_d = {w_adj[BCD_VEC_W-2:0], bin_q[DATA_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == STEP_W'(DATA_W - 1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign ovf_o  = ovf_q;
    assign bcd_o  = bcd_q;

endmodule
`default_nettype wire

// File: rtl/fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fnd_scan_ctrl
// Brief   : Binary->BCD conversion and 4-digit refresh scan for the FND decoder.
//           Optional leading-zero blanking when FND_LZ_BLANK_EN is defined.
// Revision: 1.0  initial release
// ============================================================================
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int SCAN_HZ = 1_000,
    parameter int DATA_W  = 14
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [DATA_W-1:0] i_value,
    input  logic              i_load,
    input  logic              i_en,
    output logic              o_busy,
    output logic              o_ovf,
    output logic [1:0]        o_DigitSelect,
    output logic [BCD_W-1:0]  o_bcd,
    output logic              o_en,
    output logic              o_blank
);

    localparam int P    = CLK_HZ / SCAN_HZ;
    localparam int PS_W = (P > 1) ? $clog2(P) : 1;

    logic [PS_W-1:0]      ps_q, ps_d;
    logic [1:0]           sel_q, sel_d;
    logic [BCD_VEC_W-1:0] disp_q, disp_d;
    logic                 w_tick;
    logic                 w_done;
    logic [BCD_VEC_W-1:0] w_conv_bcd;
    logic                 w_blank;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_conv (
        .clk_i     (i_clk),
        .reset_n_i (i_reset_n),
        .value_i   (i_value),
        .load_i    (i_load),
        .busy_o    (o_busy),
        .done_o    (w_done),
        .ovf_o     (o_ovf),
        .bcd_o     (w_conv_bcd)
    );

    assign w_tick = (ps_q == PS_W'(P - 1));

    always_comb begin
        ps_d   = w_tick ? '0 : ps_q + 1'b1;
        sel_d  = w_tick ? sel_q + 2'd1 : sel_q;
        disp_d = w_done ? w_conv_bcd : disp_q;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            ps_q   <= '0;
            sel_q  <= 2'd0;
            disp_q <= '0;
        end else begin
            ps_q   <= ps_d;
            sel_q  <= sel_d;
            disp_q <= disp_d;
        end
    end

`ifdef FND_LZ_BLANK_EN
    // A digit is blank when it and every more-significant digit are zero.
    logic [FND_DIGITS-1:0] w_upper_zero;
    for (genvar k = 0; k < FND_DIGITS; k++) begin : g_lz
        assign w_upper_zero[k] = (disp_q[BCD_VEC_W-1:k*BCD_W] == '0);
    end
    assign w_blank = (sel_q != 2'd0) && w_upper_zero[sel_q];
`else
    assign w_blank = 1'b0;
`endif

    assign o_DigitSelect = sel_q;
    assign o_bcd         = disp_q[{sel_q, 2'b00} +: BCD_W];
    assign o_blank       = w_blank;
    assign o_en          = i_en & ~w_blank;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fnd_scan_ctrl
// Brief   : Scoreboard bench for fnd_scan_ctrl (tick every 4 clocks).
// Revision: 1.0  initial release
// ============================================================================
module tb_fnd_scan_ctrl;

    localparam int DATA_W = 14;
    localparam int CONV_CYCLES = DATA_W + 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load;
    logic              en;
    logic [DATA_W-1:0] value;
    logic              busy, ovf, den, blank;
    logic [1:0]        sel;
    logic [3:0]        bcd;

    always #5 clk = ~clk;

    fnd_scan_ctrl #(
        .CLK_HZ  (1000),
        .SCAN_HZ (250),
        .DATA_W  (DATA_W)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_value       (value),
        .i_load        (load),
        .i_en          (en),
        .o_busy        (busy),
        .o_ovf         (ovf),
        .o_DigitSelect (sel),
        .o_bcd         (bcd),
        .o_en          (den),
        .o_blank       (blank)
    );

    typedef struct {
        int val;
        bit ovf;
    } exp_t;

    exp_t q[$];
    exp_t popped;
    int   total = 0;
    int   bad   = 0;
    int   p10[4] = '{1, 10, 100, 1000};

    // Reference state advanced at each rising edge
    int k_scan    = 0;
    int busy_rem  = 0;
    bit exp_ovf   = 1'b0;
    bit model_rst = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                k_scan    = 0;
                busy_rem  = 0;
                exp_ovf   = 1'b0;
                model_rst = 1'b1;
                q.delete();
            end else begin
                model_rst = 1'b0;
                k_scan++;
                if (busy_rem > 0) begin
                    busy_rem--;
                end else if (load) begin
                    q.push_back(exp_t'{val: (int'(value) > 9999) ? 9999 : int'(value),
                                       ovf: (int'(value) > 9999)});
                    exp_ovf  = (int'(value) > 9999);
                    busy_rem = CONV_CYCLES;
                end
            end
        end
    end

    // Monitor: pops an expected result whenever a conversion completes
    initial begin
        int  disp_model;
        int  es;
        bit  prev_busy;
        bit  exp_blank;
        disp_model = 0;
        prev_busy  = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (model_rst) begin
                disp_model = 0;
            end else if (prev_busy && !busy && q.size() > 0) begin
                popped = q.pop_front();
                check("done_ovf", int'(ovf), int'(popped.ovf));
                disp_model = popped.val;
            end
            prev_busy = busy;
            es = (k_scan / 4) % 4;
`ifdef FND_LZ_BLANK_EN
            exp_blank = (es != 0) && (disp_model < p10[es]);
`else
            exp_blank = 1'b0;
`endif
            check("select", int'(sel), es);
            check("bcd",    int'(bcd), (disp_model / p10[es]) % 10);
            check("busy",   int'(busy), int'(busy_rem > 0));
            check("ovf",    int'(ovf), int'(exp_ovf));
            check("blank",  int'(blank), int'(exp_blank));
            check("en",     int'(den), int'(en && !exp_blank));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int v);
        value = DATA_W'(v);
        load  = 1'b1;
        step(1);
        load  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        en    = 1'b1;
        value = '0;
        step(3);
        rst_n = 1'b1;
        step(20);

        do_load(1234);  step(20);
        do_load(12000); step(20);
        do_load(5);     step(20);
        do_load(42);    step(2);
        do_load(77);    step(20);
        do_load(7);     step(10);
        en = 1'b0;      step(6);
        en = 1'b1;      step(4);

        // Second load lands on the completion cycle, third one just after
        do_load(100);   step(14);
        do_load(200);
        do_load(300);   step(20);

        do_load(9999);  step(4);
        rst_n = 1'b0;   step(1);
        rst_n = 1'b1;   step(20);

        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 1));
            do_load(int'($urandom_range(0, 16383)));
            step(int'($urandom_range(0, 25)));
        end
        step(30);

        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
